// File: rtl/crc3_frame_ctrl.sv
// Frame sequencer for a serial CRC-3 (x^3+x+1) engine: accepts a parallel word,
// streams it MSB-first and either appends the CRC (GEN) or checks the remainder (CHK).
module crc3_frame_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       crc_out,
  output logic             crc_ok
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_APPEND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             mode_q, mode_d;
  logic [2:0]       crc_q, crc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       app_q, app_d;
  logic [2:0]       crc_out_q, crc_out_d;
  logic             crc_ok_q, crc_ok_d;

  logic             fb;
  logic [2:0]       crc_step;

  // State and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      mode_q    <= 1'b0;
      crc_q     <= 3'b000;
      count_q   <= '0;
      app_q     <= 2'd0;
      crc_out_q <= 3'b000;
      crc_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      mode_q    <= mode_d;
      crc_q     <= crc_d;
      count_q   <= count_d;
      app_q     <= app_d;
      crc_out_q <= crc_out_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    mode_d     = mode_q;
    crc_d      = crc_q;
    count_d    = count_q;
    app_d      = app_q;
    crc_out_d  = crc_out_q;
    crc_ok_d   = crc_ok_q;
    in_ready   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    // One LFSR step with the bit currently at the head of the shift register
    fb       = shreg_q[WIDTH-1] ^ crc_q[2];
    crc_step = {crc_q[1], crc_q[0] ^ fb, fb};

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = din;
          mode_d  = mode;
          crc_d   = 3'b000;
          count_d = CW'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy       = 1'b1;
        sout       = shreg_q[WIDTH-1];
        sout_valid = 1'b1;
        crc_d      = crc_step;
        shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
        count_d    = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          crc_out_d = crc_step;
          if (mode_q) begin
            crc_ok_d = (crc_step == 3'b000);
            state_d  = S_DONE;
          end else begin
            app_d   = 2'd0;
            state_d = S_APPEND;
          end
        end
      end
      S_APPEND: begin
        busy       = 1'b1;
        sout       = crc_q[2];
        sout_valid = 1'b1;
        crc_d      = {crc_q[1:0], 1'b0};
        app_d      = app_q + 2'd1;
        if (app_q == 2'd2) begin
          crc_ok_d = (crc_out_q == 3'b000);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign crc_out = crc_out_q;
  assign crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_crc3_frame_ctrl.sv
// Directed bench for crc3_frame_ctrl: cycle-exact serial streams and results
// for GEN/CHK frames, back-to-back accepts, busy-time input noise and mid-frame reset.
module tb_crc3_frame_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             mode;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;
  logic [2:0]       crc_out;
  logic             crc_ok;

  int errors = 0;
  int checks = 0;

  crc3_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .mode       (mode),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done),
    .crc_out    (crc_out),
    .crc_ok     (crc_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_idle_rdy"},  64'(in_ready),   64'd1);
    check_val({tag, "_idle_busy"}, 64'(busy),       64'd0);
    check_val({tag, "_idle_sv"},   64'(sout_valid), 64'd0);
    check_val({tag, "_idle_done"}, 64'(done),       64'd0);
  endtask

  task automatic accept(input logic [WIDTH-1:0] d, input logic m);
    in_valid = 1'b1;
    din      = d;
    mode     = m;
    tick();
  endtask

  // Checks n serial cycles; poke >= 0 pulses in_valid with junk data on that cycle
  task automatic shift_bits(input string tag, input logic [10:0] bits, input int n, input int poke);
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_sv%0d", tag, i),   64'(sout_valid), 64'd1);
      check_val($sformatf("%s_sout%0d", tag, i), 64'(sout),       64'(bits[n-1-i]));
      check_val($sformatf("%s_rdy%0d", tag, i),  64'(in_ready),   64'd0);
      check_val($sformatf("%s_busy%0d", tag, i), 64'(busy),       64'd1);
      check_val($sformatf("%s_done%0d", tag, i), 64'(done),       64'd0);
      if (i == poke) begin
        in_valid = 1'b1;
        din      = 8'hFF;
        mode     = 1'b1;
      end else if (poke >= 0) begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic done_check(input string tag, input logic [2:0] ecrc, input logic eok);
    check_val({tag, "_done"},    64'(done),       64'd1);
    check_val({tag, "_done_sv"}, 64'(sout_valid), 64'd0);
    check_val({tag, "_done_rdy"},64'(in_ready),   64'd0);
    check_val({tag, "_done_bsy"},64'(busy),       64'd1);
    check_val({tag, "_crc"},     64'(crc_out),    64'(ecrc));
    check_val({tag, "_ok"},      64'(crc_ok),     64'(eok));
    tick();
  endtask

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    din      = '0;
    mode     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rdy",  64'(in_ready),   64'd1);
    check_val("rst_sv",   64'(sout_valid), 64'd0);
    check_val("rst_sout", 64'(sout),       64'd0);
    check_val("rst_busy", 64'(busy),       64'd0);
    check_val("rst_done", 64'(done),       64'd0);
    check_val("rst_crc",  64'(crc_out),    64'd0);
    check_val("rst_ok",   64'(crc_ok),     64'd0);
    clr = 1'b0;
    tick();
    check_idle("init");

    // GEN 0xD3: data then crc 011
    accept(8'hD3, 1'b0);
    in_valid = 1'b0;
    shift_bits("gen_d3", 11'b11010011011, 11, -1);
    done_check("gen_d3", 3'b011, 1'b0);
    check_idle("gen_d3");

    // CHK clean codeword
    accept(8'hD2, 1'b1);
    in_valid = 1'b0;
    shift_bits("chk_d2", 11'h0D2, 8, -1);
    done_check("chk_d2", 3'b000, 1'b1);
    check_idle("chk_d2");

    // CHK with a single-bit error
    accept(8'hD3, 1'b1);
    in_valid = 1'b0;
    shift_bits("chk_d3", 11'h0D3, 8, -1);
    done_check("chk_d3", 3'b011, 1'b0);
    check_idle("chk_d3");

    // Back-to-back with in_valid held high; next word presented during busy
    accept(8'h00, 1'b0);
    din  = 8'hD2;
    mode = 1'b1;
    shift_bits("b2b0", 11'h000, 11, -1);
    done_check("b2b0", 3'b000, 1'b1);
    check_val("b2b_accept_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    shift_bits("b2b1", 11'h0D2, 8, -1);
    done_check("b2b1", 3'b000, 1'b1);
    check_idle("b2b1");

    // Input noise during SHIFT must not disturb the frame
    accept(8'hD3, 1'b0);
    in_valid = 1'b0;
    shift_bits("ign", 11'b11010011011, 11, 3);
    done_check("ign", 3'b011, 1'b0);
    check_idle("ign");
    tick();
    check_idle("ign_after");

    // Reset in mid-frame abandons it
    accept(8'hD2, 1'b1);
    in_valid = 1'b0;
    shift_bits("rst_pre", 11'b110, 3, -1);
    clr = 1'b1;
    #1;
    check_val("mid_rst_rdy",  64'(in_ready),   64'd1);
    check_val("mid_rst_sv",   64'(sout_valid), 64'd0);
    check_val("mid_rst_sout", 64'(sout),       64'd0);
    check_val("mid_rst_busy", 64'(busy),       64'd0);
    check_val("mid_rst_done", 64'(done),       64'd0);
    check_val("mid_rst_crc",  64'(crc_out),    64'd0);
    check_val("mid_rst_ok",   64'(crc_ok),     64'd0);
    tick();
    clr = 1'b0;
    check_idle("post_rst");
    tick();
    check_idle("post_rst2");

    accept(8'hD2, 1'b1);
    in_valid = 1'b0;
    shift_bits("post_chk", 11'h0D2, 8, -1);
    done_check("post_chk", 3'b000, 1'b1);
    check_idle("post_chk");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
